// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_BLANK = 4'hF;
  localparam bcd_digit_t BCD_NINE  = 4'h9;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic logic [31:0] max_value(input int digits);
    logic [31:0] m;
    m = 32'd1;
    for (int i = 0; i < digits; i++) begin
      m = m * 32'd10;
    end
    return m - 32'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the register source and the BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int DIGITS = 4
);

  logic [31:0]         reg_32_i;
  logic                valid_i;
  logic                ready_o;
  logic [4*DIGITS-1:0] bcd_o;
  logic                done_o;
  logic                ovf_o;

  // Source side: offers a value and watches the result.
  modport master (
    output reg_32_i, valid_i,
    input  ready_o, bcd_o, done_o, ovf_o
  );

  // Converter side.
  modport slave (
    input  reg_32_i, valid_i,
    output ready_o, bcd_o, done_o, ovf_o
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a nibble of 5..9 gets +3 before the shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t nib,
  output bcd_digit_t adj
);

  // Inputs never exceed 9, so the 4-bit sum cannot wrap.
  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock.
// Optional build macro BCD_LEAD_ZERO_BLANK_EN: leading zero digits above
// digit 0 are replaced by the blank code in the final result.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int IN_W   = 14
) (
  input logic clk_i,
  input logic rst_i,
  bin_to_bcd_seq_if.slave bus
);

  localparam int          BW    = 4 * DIGITS;
  localparam int          CNT_W = $clog2(IN_W);
  localparam logic [31:0] MAX   = max_value(DIGITS);

  state_t            state_reg, state_next;
  logic [IN_W-1:0]   value_reg;
  logic [BW-1:0]     scratch_reg;
  logic [BW-1:0]     scratch_adj;
  logic [BW-1:0]     result;
  logic [CNT_W-1:0]  cnt_reg;
  logic              ovf_lat_reg;
  logic [BW-1:0]     bcd_reg;
  logic              ovf_reg;
  logic              done_reg;
  logic              ready;
  logic              load;
  logic              shift;
  logic              finish;

  // Per-digit add-3 correction ahead of each shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .nib (scratch_reg[4*gi +: 4]),
        .adj (scratch_adj[4*gi +: 4])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.valid_i) state_next = SHIFT;
      SHIFT:   if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath-control decode.
  always_comb begin
    ready  = 1'b0;
    load   = 1'b0;
    shift  = 1'b0;
    finish = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        load  = bus.valid_i;
      end
      SHIFT:   shift  = 1'b1;
      DONE:    finish = 1'b1;
      default: ready  = 1'b0;
    endcase
  end

  // Final digit pattern before saturation; optionally blanks leading zeros.
  always_comb begin
    result = scratch_reg;
`ifdef BCD_LEAD_ZERO_BLANK_EN
    begin : blank
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (lead && (scratch_reg[4*i +: 4] == 4'd0)) result[4*i +: 4] = BCD_BLANK;
        else                                          lead = 1'b0;
      end
    end
`endif
  end

  // Conversion datapath and registered results.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_reg   <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      ovf_lat_reg <= 1'b0;
      bcd_reg     <= '0;
      ovf_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load) begin
        value_reg   <= bus.reg_32_i[IN_W-1:0];
        ovf_lat_reg <= (bus.reg_32_i > MAX);
        scratch_reg <= '0;
        cnt_reg     <= CNT_W'(IN_W - 1);
      end
      if (shift) begin
        scratch_reg <= {scratch_adj[BW-2:0], value_reg[IN_W-1]};
        value_reg   <= {value_reg[IN_W-2:0], 1'b0};
        if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
      end
      if (finish) begin
        bcd_reg  <= ovf_lat_reg ? {DIGITS{BCD_NINE}} : result;
        ovf_reg  <= ovf_lat_reg;
        done_reg <= 1'b1;
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.bcd_o   = bcd_reg;
  assign bus.ovf_o   = ovf_reg;
  assign bus.done_o  = done_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq (DIGITS=4, IN_W=14).
module tb_bin_to_bcd_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   pulses;
  int   p0;
  logic [15:0] last_bcd;
  logic        last_ovf;

  bin_to_bcd_seq_if #(.DIGITS(4)) bus ();

  bin_to_bcd_seq #(.DIGITS(4), .IN_W(14)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done_o is high for a whole cycle, so one falling-edge sample per pulse.
  always @(negedge clk) if (bus.done_o === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic convert(input logic [31:0] v, input logic [15:0] eb, input logic eo,
                         input bit inject);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.reg_32_i = v;
    bus.valid_i  = 1'b1;
    @(posedge clk); #1;
    bus.valid_i  = 1'b0;
    bus.reg_32_i = 32'hDEAD_BEEF;
    check("ready_busy", {31'd0, bus.ready_o}, 32'd0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (inject && k == 3) begin
        bus.reg_32_i = 32'd7;
        bus.valid_i  = 1'b1;
      end
      if (inject && k == 6) bus.valid_i = 1'b0;
      if (k == 7) begin
        check("hold_bcd", {16'd0, bus.bcd_o}, {16'd0, last_bcd});
        check("hold_ovf", {31'd0, bus.ovf_o}, {31'd0, last_ovf});
      end
      if (bus.done_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, 32'd15);
    check("bcd", {16'd0, bus.bcd_o}, {16'd0, eb});
    check("ovf", {31'd0, bus.ovf_o}, {31'd0, eo});
    $display("conv in=%0d bcd=%h ovf=%b latency=%0d", v, bus.bcd_o, bus.ovf_o, lat);
    last_bcd = eb;
    last_ovf = eo;
    @(posedge clk); #1;
    check("done_once", {31'd0, bus.done_o}, 32'd0);
    check("ready_back", {31'd0, bus.ready_o}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    last_bcd = 16'h0000;
    last_ovf = 1'b0;
    bus.reg_32_i = 32'd0;
    bus.valid_i  = 1'b0;
    rst = 1'b1;
    #12;
    check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
    check("rst_bcd", {16'd0, bus.bcd_o}, 32'd0);
    check("rst_done", {31'd0, bus.done_o}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    convert(32'd1234, 16'h1234, 1'b0, 1'b0);
`ifdef BCD_LEAD_ZERO_BLANK_EN
    convert(32'd0, 16'hFFF0, 1'b0, 1'b0);
`else
    convert(32'd0, 16'h0000, 1'b0, 1'b0);
`endif
    convert(32'd9999, 16'h9999, 1'b0, 1'b0);
    convert(32'd10000, 16'h9999, 1'b1, 1'b0);
    convert(32'h8000_0000, 16'h9999, 1'b1, 1'b0);

    // A request during SHIFT is dropped; only the two accepted ones complete.
    p0 = pulses;
`ifdef BCD_LEAD_ZERO_BLANK_EN
    convert(32'd42, 16'hFF42, 1'b0, 1'b1);
    convert(32'd7, 16'hFFF7, 1'b0, 1'b0);
`else
    convert(32'd42, 16'h0042, 1'b0, 1'b1);
    convert(32'd7, 16'h0007, 1'b0, 1'b0);
`endif
    check("two_pulses", pulses - p0, 32'd2);

    // Reset in the middle of a conversion.
    @(negedge clk);
    bus.reg_32_i = 32'd5678;
    bus.valid_i  = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    p0 = pulses;
    rst = 1'b1;
    #1;
    check("abort_bcd", {16'd0, bus.bcd_o}, 32'd0);
    check("abort_ready", {31'd0, bus.ready_o}, 32'd1);
    check("abort_ovf", {31'd0, bus.ovf_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", pulses - p0, 32'd0);
    $display("abort bcd=%h ready=%b", bus.bcd_o, bus.ready_o);
    last_bcd = 16'h0000;
    last_ovf = 1'b0;

    convert(32'd5678, 16'h5678, 1'b0, 1'b0);
    convert(32'd1000, 16'h1000, 1'b0, 1'b0);
    convert(32'd12000, 16'h9999, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
